bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bcd_pkg.sv | 41 ++++
 rtl/bin_to_bcd_seq_if.sv | 27 ++
 rtl/bcd_add3_digit.sv | 15 +
 rtl/bin_to_bcd_seq.sv | 122 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, types and elaboration helpers for the binary-to-BCD converter.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 40; i++) begin
      if ((longint'(1) << r) < longint'(value)) r++;
    end
    return r;
  endfunction

  // Decimal digits needed for any w-bit unsigned value, i.e. ceil(w*log10(2)):
  // the smallest d with 10**d >= 2**w.
  function automatic int min_digits(input int w);
    longint unsigned lim;
    longint unsigned p;
    int              d;
    lim = 64'd1 << w;
    p   = 64'd1;
    d   = 0;
    for (int i = 0; i < 40; i++) begin
      if (p < lim) begin
        p = p * 64'd10;
        d++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/operand/result bundle between a requester and the BCD converter.
// Latency: n/a (wires only).
// Backpressure: none; the requester watches EN_conv/ok_conv.
interface bin_to_bcd_seq_if #(
  parameter int W  = 16,
  parameter int D  = 5,
  parameter int CW = 5
);
  logic             st;
  logic [W-1:0]     FBI;
  logic             sgn;
  logic [4*D-1:0]   FDO;
  logic             neg;
  logic [CW-1:0]    cb_tact;
  logic             EN_conv;
  logic             ok_conv;

  modport master (
    output st, FBI, sgn,
    input  FDO, neg, cb_tact, EN_conv, ok_conv
  );

  modport slave (
    input  st, FBI, sgn,
    output FDO, neg, cb_tact, EN_conv, ok_conv
  );
endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational.
// Backpressure: n/a.
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // A digit >= 5 would reach >= 10 after the next shift, so pre-correct it.
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: signed/unsigned W-bit binary to D BCD digits plus sign.
// Latency: ok_conv high W+1 cycles after the cycle st is captured; one conversion per W+1 cycles.
// Backpressure: none; st is ignored while EN_conv=1 and is accepted again in the ok_conv cycle.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int W  = 16,
  parameter int D  = 5,
  parameter int CW = clog2(W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  bin_to_bcd_seq_if.slave   bus
);

  localparam int AW = BCD_DIGIT_W * D;

  if (W < 4 || W > 32) begin : g_bad_w
    $error("bin_to_bcd_seq: W must be in 4..32");
  end
  if (D < min_digits(W)) begin : g_bad_d
    $error("bin_to_bcd_seq: D too small to hold every W-bit magnitude");
  end
  if (CW < clog2(W + 1)) begin : g_bad_cw
    $error("bin_to_bcd_seq: CW too narrow to count to W");
  end

  state_e          state_q,    state_d;
  logic [W-1:0]    mag_q,      mag_d;
  logic [AW-1:0]   acc_q,      acc_d;
  logic [CW-1:0]   cb_tact_q,  cb_tact_d;
  logic            neg_cand_q, neg_cand_d;
  logic [AW-1:0]   fdo_q,      fdo_d;
  logic            neg_q,      neg_d;
  logic            en_conv_q,  en_conv_d;
  logic            ok_conv_q,  ok_conv_d;

  logic [AW-1:0]   acc_corr;
  logic [AW+W-1:0] shift_vec;

  for (genvar g = 0; g < D; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .din  (acc_q   [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (acc_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The corrected accumulator and the remaining magnitude shift as one register.
  assign shift_vec = {acc_corr, mag_q} << 1;

  // Next-state: capture in IDLE, one double-dabble step per SHIFT cycle, publish on the last step.
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    acc_d      = acc_q;
    cb_tact_d  = cb_tact_q;
    neg_cand_d = neg_cand_q;
    fdo_d      = fdo_q;
    neg_d      = neg_q;
    en_conv_d  = en_conv_q;
    ok_conv_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.st) begin
          // Two's-complement negate also maps the most negative value onto its own magnitude.
          mag_d      = (bus.sgn && bus.FBI[W-1]) ? (~bus.FBI + W'(1)) : bus.FBI;
          neg_cand_d = bus.sgn & bus.FBI[W-1];
          acc_d      = '0;
          cb_tact_d  = '0;
          en_conv_d  = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d     = shift_vec[AW+W-1:W];
        mag_d     = shift_vec[W-1:0];
        cb_tact_d = cb_tact_q + CW'(1);
        if (cb_tact_q == CW'(W - 1)) begin
          fdo_d     = shift_vec[AW+W-1:W];
          neg_d     = neg_cand_q;
          ok_conv_d = 1'b1;
          en_conv_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset wins over any start or in-flight conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mag_q      <= '0;
      acc_q      <= '0;
      cb_tact_q  <= '0;
      neg_cand_q <= 1'b0;
      fdo_q      <= '0;
      neg_q      <= 1'b0;
      en_conv_q  <= 1'b0;
      ok_conv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      acc_q      <= acc_d;
      cb_tact_q  <= cb_tact_d;
      neg_cand_q <= neg_cand_d;
      fdo_q      <= fdo_d;
      neg_q      <= neg_d;
      en_conv_q  <= en_conv_d;
      ok_conv_q  <= ok_conv_d;
    end
  end

  assign bus.FDO     = fdo_q;
  assign bus.neg     = neg_q;
  assign bus.cb_tact = cb_tact_q;
  assign bus.EN_conv = en_conv_q;
  assign bus.ok_conv = ok_conv_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a W=16/D=5 and a W=8/D=3 instance.
// Stimulus pushes expected {FDO, neg, issue cycle}; per-instance monitors pop on ok_conv.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_bin_to_bcd_seq;

  typedef struct {
    logic [31:0] fdo;
    logic        neg;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  exp_t q16[$];
  exp_t q8[$];
  logic prev_ok16;
  logic prev_ok8;

  bin_to_bcd_seq_if #(.W(16), .D(5), .CW(5)) b16 ();
  bin_to_bcd_seq_if #(.W(8),  .D(3), .CW(4)) b8 ();

  bin_to_bcd_seq #(.W(16), .D(5), .CW(5)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );

  bin_to_bcd_seq #(.W(8), .D(3), .CW(4)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (b16.ok_conv === 1'b1) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ok16_unexpected: got ok_conv=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("fdo16", 32'(b16.FDO), e.fdo);
        chk("neg16", 32'(b16.neg), 32'(e.neg));
        chk("lat16", 32'(cyc - e.cyc), 32'd17);
        chk("en16_at_done", 32'(b16.EN_conv), 32'd0);
      end
      chk("ok16_width", 32'(prev_ok16), 32'd0);
    end
    prev_ok16 = b16.ok_conv;
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (b8.ok_conv === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ok8_unexpected: got ok_conv=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("fdo8", 32'(b8.FDO), e.fdo);
        chk("neg8", 32'(b8.neg), 32'(e.neg));
        chk("lat8", 32'(cyc - e.cyc), 32'd9);
      end
      chk("ok8_width", 32'(prev_ok8), 32'd0);
    end
    prev_ok8 = b8.ok_conv;
  end

  // Called on a falling edge; leaves st low one falling edge later.
  task automatic issue16(input logic [15:0] v, input logic s, input logic [19:0] efdo,
                         input logic eneg, input bit push);
    exp_t e;
    b16.st  = 1'b1;
    b16.FBI = v;
    b16.sgn = s;
    if (push) begin
      e.fdo = 32'(efdo);
      e.neg = eneg;
      e.cyc = cyc;
      q16.push_back(e);
    end
    @(negedge clk);
    b16.st = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] v, input logic s, input logic [11:0] efdo,
                        input logic eneg);
    exp_t e;
    b8.st  = 1'b1;
    b8.FBI = v;
    b8.sgn = s;
    e.fdo  = 32'(efdo);
    e.neg  = eneg;
    e.cyc  = cyc;
    q8.push_back(e);
    @(negedge clk);
    b8.st = 1'b0;
  endtask

  // Returns on the falling edge where ok_conv is seen, or flags a timeout.
  task automatic wait_ok16(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (b16.ok_conv === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ok_conv expected one within 60 cycles", nm);
    end
  endtask

  task automatic wait_ok8(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (b8.ok_conv === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ok_conv expected one within 40 cycles", nm);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    prev_ok16 = 1'b0;
    prev_ok8  = 1'b0;
    rst       = 1'b1;
    b16.st    = 1'b1;   // start held during reset must not launch anything
    b16.FBI   = 16'h1234;
    b16.sgn   = 1'b0;
    b8.st     = 1'b0;
    b8.FBI    = 8'h00;
    b8.sgn    = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst16_fdo",  32'(b16.FDO),     32'd0);
    chk("rst16_neg",  32'(b16.neg),     32'd0);
    chk("rst16_tact", 32'(b16.cb_tact), 32'd0);
    chk("rst16_en",   32'(b16.EN_conv), 32'd0);
    chk("rst16_ok",   32'(b16.ok_conv), 32'd0);
    chk("rst8_fdo",   32'(b8.FDO),      32'd0);
    chk("rst8_en",    32'(b8.EN_conv),  32'd0);
    rst    = 1'b0;
    b16.st = 1'b0;
    @(negedge clk);
    chk("rst_st_no_start", 32'(b16.EN_conv), 32'd0);

    // Basic unsigned conversion, then cb_tact holds W while idle.
    issue16(16'h4D3A, 1'b0, 20'h19770, 1'b0, 1'b1);
    chk("busy16", 32'(b16.EN_conv), 32'd1);
    wait_ok16("t_19770");
    repeat (3) @(negedge clk);
    chk("tact16_hold", 32'(b16.cb_tact), 32'd16);
    chk("idle16_en",   32'(b16.EN_conv), 32'd0);

    // Max unsigned; a second st mid-conversion is ignored and FDO keeps the old result.
    issue16(16'hFFFF, 1'b0, 20'h65535, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    b16.st  = 1'b1;
    b16.FBI = 16'h0001;
    chk("mid_fdo_hold", 32'(b16.FDO), 32'h19770);
    chk("mid_en",       32'(b16.EN_conv), 32'd1);
    @(negedge clk);
    b16.st = 1'b0;
    wait_ok16("t_65535");
    repeat (25) @(negedge clk);
    chk("ignored_st_no_extra", 32'(q16.size()), 32'd0);

    // Signed zero, then most negative followed back-to-back by -1.
    issue16(16'h0000, 1'b1, 20'h00000, 1'b0, 1'b1);
    wait_ok16("t_zero");
    issue16(16'h8000, 1'b1, 20'h32768, 1'b1, 1'b1);
    wait_ok16("t_m32768");
    issue16(16'hFFFF, 1'b1, 20'h00001, 1'b1, 1'b1);
    wait_ok16("t_m1");
    issue16(16'h7FFF, 1'b1, 20'h32767, 1'b0, 1'b1);
    wait_ok16("t_32767");
    issue16(16'hFF85, 1'b1, 20'h00123, 1'b1, 1'b1);
    wait_ok16("t_m123");

    // Reset abort at cycle 8: outputs clear, no ok_conv, next start works.
    issue16(16'h1234, 1'b0, 20'h0, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_fdo",  32'(b16.FDO),     32'd0);
    chk("abort_neg",  32'(b16.neg),     32'd0);
    chk("abort_tact", 32'(b16.cb_tact), 32'd0);
    chk("abort_en",   32'(b16.EN_conv), 32'd0);
    chk("abort_ok",   32'(b16.ok_conv), 32'd0);
    repeat (25) @(negedge clk);
    issue16(16'h0309, 1'b0, 20'h00777, 1'b0, 1'b1);
    wait_ok16("t_777");

    // Narrow build.
    issue8(8'hFF, 1'b0, 12'h255, 1'b0);
    wait_ok8("t8_255");
    issue8(8'h80, 1'b1, 12'h128, 1'b1);
    wait_ok8("t8_m128");
    issue8(8'h9C, 1'b1, 12'h100, 1'b1);
    wait_ok8("t8_m100");
    repeat (3) @(negedge clk);
    chk("tact8_hold", 32'(b8.cb_tact), 32'd8);

    repeat (5) @(negedge clk);
    chk("q16_drained", 32'(q16.size()), 32'd0);
    chk("q8_drained",  32'(q8.size()),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
